pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/riscv_pkg.sv | 42 ++++
 rtl/hazard_perf_cnt.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Opcode constants, source-register usage helpers and the hazard controller
//   state encoding. Shared by the hazard controller and the forwarding unit so
//   both agree on which instructions read rs1/rs2.
package riscv_pkg;

  localparam logic [6:0] MATHr  = 7'b0110011;
  localparam logic [6:0] MATHWr = 7'b0111011;
  localparam logic [6:0] MATHi  = 7'b0010011;
  localparam logic [6:0] MATHWi = 7'b0011011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] LW     = 7'b0000011;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  // Per-cycle hazard decision: one flag per cause, at most one set.
  typedef struct packed {
    logic mem;
    logic mdu;
    logic redirect;
    logic load_use;
  } hz_cause_t;

  // rs1 field is an immediate (or absent) only for the U/J-type opcodes.
  function automatic logic rs1_used(input logic [6:0] opcode);
    return !((opcode == JAL) || (opcode == LUI) || (opcode == AUIPC));
  endfunction

  function automatic logic rs2_used(input logic [6:0] opcode);
    return (opcode == MATHr) || (opcode == MATHWr) ||
           (opcode == BRANCH) || (opcode == SW);
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt
//   32-bit saturating event counter for hazard statistics.
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset, clears the count
//   inc  : count this cycle
//   cnt  : current count, sticks at 0xFFFFFFFF
module hazard_perf_cnt (
  input  logic        clk,
  input  logic        rstn,
  input  logic        inc,
  output logic [31:0] cnt
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (inc && (cnt != 32'hFFFF_FFFF)) begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Pipeline hazard controller: load-use interlock, branch/JAL redirect flush,
//   multi-cycle MDU wait and data-memory wait. All outputs are combinational
//   from the registered state and the current inputs (zero-cycle response).
//
//   Ports
//     clk, rstn          : clock, asynchronous active-low reset
//     IDinst             : instruction in ID
//     EXrd/EXwe_reg/EXre_mem : EX destination, writes-RF, is-load
//     EXredirect         : taken branch or JAL in EX
//     mdu_req/mdu_done   : multi-cycle mul/div in EX / result-ready pulse
//     MEMre_mem/MEMwe_mem: MEM-stage load / store
//     dmem_ready         : data memory access complete
//     stall_IF/ID/EX/MEM : hold PC, IF/ID, ID/EX, EX/MEM
//     flush_ID           : zero IF/ID
//     bubble_EX/MEM      : load NOP into ID/EX, EX/MEM
//     busy               : state is not RUN
//
//   Build option HAZARD_PERF_EN adds 32-bit saturating counters
//   cnt_loaduse, cnt_redirect, cnt_mdu, cnt_mem.
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   RUN      | normal flow; evaluate mem > mdu > redirect > load-use
//   MDU_WAIT | mul/div in EX, hold front end, bubble MEM until done
//   MEM_WAIT | data memory outstanding, freeze all stages until ready
module pipe_hazard_ctrl
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] IDinst,
  input  logic [4:0]  EXrd,
  input  logic        EXwe_reg,
  input  logic        EXre_mem,
  input  logic        EXredirect,
  input  logic        mdu_req,
  input  logic        mdu_done,
  input  logic        MEMre_mem,
  input  logic        MEMwe_mem,
  input  logic        dmem_ready,
  output logic        stall_IF,
  output logic        stall_ID,
  output logic        stall_EX,
  output logic        stall_MEM,
  output logic        flush_ID,
  output logic        bubble_EX,
  output logic        bubble_MEM,
  output logic        busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] cnt_loaduse,
  output logic [31:0] cnt_redirect,
  output logic [31:0] cnt_mdu,
  output logic [31:0] cnt_mem
`endif
);

  hz_state_t   state;
  hz_state_t   state_nxt;
  hz_cause_t   cause;

  logic [6:0]  id_opcode;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        load_use;
  logic        mem_pending;
  logic        unused_bits;

  assign id_opcode   = IDinst[6:0];
  assign id_rs1      = IDinst[19:15];
  assign id_rs2      = IDinst[24:20];
  assign unused_bits = ^{IDinst[31:25], IDinst[14:7]};

  // x0 is never a real dependency, so a load to x0 cannot interlock.
  assign load_use = EXre_mem && EXwe_reg && (EXrd != 5'd0) &&
                    ((rs1_used(id_opcode) && (EXrd == id_rs1)) ||
                     (rs2_used(id_opcode) && (EXrd == id_rs2)));

  assign mem_pending = MEMre_mem || MEMwe_mem;

  // Only RUN looks at redirect/load-use; in the wait states they are ignored
  // and re-evaluated on whatever inputs are present after returning to RUN.
  always_comb begin
    state_nxt = state;
    cause     = '0;
    unique case (state)
      RUN: begin
        if (mem_pending && !dmem_ready) begin
          cause.mem = 1'b1;
          state_nxt = MEM_WAIT;
        end else if (mdu_req && !mdu_done) begin
          cause.mdu = 1'b1;
          state_nxt = MDU_WAIT;
        end else if (EXredirect) begin
          cause.redirect = 1'b1;
        end else if (load_use) begin
          cause.load_use = 1'b1;
        end
      end
      MDU_WAIT: begin
        if (mdu_done) begin
          state_nxt = RUN;
        end else begin
          cause.mdu = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_nxt = RUN;
        end else begin
          cause.mem = 1'b1;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs are gated by rstn so the pipeline sees no control while in reset,
  // even though the data inputs may still be toggling.
  // Stage-register pairing: IF/ID is either held (stall_ID) or zeroed
  // (flush_ID), ID/EX held (stall_EX) or bubbled (bubble_EX), EX/MEM held
  // (stall_MEM) or bubbled (bubble_MEM); causes are exclusive so the pairs
  // never collide.
  assign stall_IF   = rstn && (cause.mem || cause.mdu || cause.load_use);
  assign stall_ID   = rstn && (cause.mem || cause.mdu || cause.load_use);
  assign stall_EX   = rstn && (cause.mem || cause.mdu);
  assign stall_MEM  = rstn && cause.mem;
  assign flush_ID   = rstn && cause.redirect;
  assign bubble_EX  = rstn && (cause.redirect || cause.load_use);
  assign bubble_MEM = rstn && cause.mdu;
  assign busy       = rstn && (state != RUN);

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt u_cnt_loaduse (
    .clk  (clk),
    .rstn (rstn),
    .inc  (cause.load_use),
    .cnt  (cnt_loaduse)
  );

  hazard_perf_cnt u_cnt_redirect (
    .clk  (clk),
    .rstn (rstn),
    .inc  (cause.redirect),
    .cnt  (cnt_redirect)
  );

  hazard_perf_cnt u_cnt_mdu (
    .clk  (clk),
    .rstn (rstn),
    .inc  (cause.mdu),
    .cnt  (cnt_mdu)
  );

  hazard_perf_cnt u_cnt_mem (
    .clk  (clk),
    .rstn (rstn),
    .inc  (cause.mem),
    .cnt  (cnt_mem)
  );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl. Output vector order used in checks:
//   {stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, bubble_EX, bubble_MEM, busy}
//   Optional build macro: HAZARD_PERF_EN (connects and checks counters).
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] IDinst;
  logic [4:0]  EXrd;
  logic        EXwe_reg, EXre_mem, EXredirect;
  logic        mdu_req, mdu_done;
  logic        MEMre_mem, MEMwe_mem, dmem_ready;
  logic        stall_IF, stall_ID, stall_EX, stall_MEM;
  logic        flush_ID, bubble_EX, bubble_MEM, busy;
`ifdef HAZARD_PERF_EN
  logic [31:0] cnt_loaduse, cnt_redirect, cnt_mdu, cnt_mem;
`endif

  int errors = 0;
  int checks = 0;

  // add x6,x5,x7 / lui x5,0x28 (rs1 field=5) / addi x6,x0,5 (rs2 field=5)
  // sw x5,0(x8) / add x6,x0,x7
  localparam logic [31:0] I_ADD  = {7'd0, 5'd7, 5'd5, 3'd0, 5'd6, 7'b0110011};
  localparam logic [31:0] I_LUI  = {20'h00028, 5'd5, 7'b0110111};
  localparam logic [31:0] I_ADDI = {12'd5, 5'd0, 3'd0, 5'd6, 7'b0010011};
  localparam logic [31:0] I_SW   = {7'd0, 5'd5, 5'd8, 3'b010, 5'd0, 7'b0100011};
  localparam logic [31:0] I_ADD0 = {7'd0, 5'd7, 5'd0, 3'd0, 5'd6, 7'b0110011};

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .IDinst     (IDinst),
    .EXrd       (EXrd),
    .EXwe_reg   (EXwe_reg),
    .EXre_mem   (EXre_mem),
    .EXredirect (EXredirect),
    .mdu_req    (mdu_req),
    .mdu_done   (mdu_done),
    .MEMre_mem  (MEMre_mem),
    .MEMwe_mem  (MEMwe_mem),
    .dmem_ready (dmem_ready),
    .stall_IF   (stall_IF),
    .stall_ID   (stall_ID),
    .stall_EX   (stall_EX),
    .stall_MEM  (stall_MEM),
    .flush_ID   (flush_ID),
    .bubble_EX  (bubble_EX),
    .bubble_MEM (bubble_MEM),
    .busy       (busy)
`ifdef HAZARD_PERF_EN
    ,
    .cnt_loaduse  (cnt_loaduse),
    .cnt_redirect (cnt_redirect),
    .cnt_mdu      (cnt_mdu),
    .cnt_mem      (cnt_mem)
`endif
  );

  function automatic logic [7:0] outs();
    return {stall_IF, stall_ID, stall_EX, stall_MEM,
            flush_ID, bubble_EX, bubble_MEM, busy};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check outputs mid-cycle, then advance to just after the next rising edge.
  task automatic step(input string tag, input logic [7:0] exp);
    @(negedge clk);
    chk(tag, {24'd0, outs()}, {24'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    IDinst     = 32'h0000_0013;
    EXrd       = 5'd0;
    EXwe_reg   = 1'b0;
    EXre_mem   = 1'b0;
    EXredirect = 1'b0;
    mdu_req    = 1'b0;
    mdu_done   = 1'b0;
    MEMre_mem  = 1'b0;
    MEMwe_mem  = 1'b0;
    dmem_ready = 1'b1;
  endtask

  initial begin
    // Reset with hazardous inputs present: everything must read 0.
    idle_inputs();
    rstn       = 1'b0;
    mdu_req    = 1'b1;
    MEMre_mem  = 1'b1;
    dmem_ready = 1'b0;
    EXredirect = 1'b1;
    #3;
    chk("reset_outs", {24'd0, outs()}, 32'd0);
    @(posedge clk);
    #1;
    idle_inputs();
    rstn = 1'b1;
    step("idle_after_reset", 8'h00);

    // Load-use on rs1: lw x5 in EX, add x6,x5,x7 in ID.
    EXrd = 5'd5; EXre_mem = 1'b1; EXwe_reg = 1'b1; IDinst = I_ADD;
    step("loaduse_rs1", 8'hC4);
    EXre_mem = 1'b0; EXwe_reg = 1'b0;
    step("loaduse_released", 8'h00);

    EXre_mem = 1'b1; EXwe_reg = 1'b1;
    IDinst = I_LUI;
    step("lui_no_stall", 8'h00);
    IDinst = I_ADDI;
    step("addi_no_stall", 8'h00);
    IDinst = I_SW;
    step("sw_rs2_stall", 8'hC4);
    EXrd = 5'd0; IDinst = I_ADD0;
    step("lw_x0_no_stall", 8'h00);

    // Redirect beats load-use.
    EXrd = 5'd5; IDinst = I_ADD; EXredirect = 1'b1;
    step("redirect_over_loaduse", 8'h0C);
    idle_inputs();

    // MDU wait, done in cycle 4; redirect raised while busy is deferred.
    mdu_req = 1'b1;
    step("mdu_c0", 8'hE2);
    step("mdu_c1", 8'hE3);
    EXredirect = 1'b1;
    step("mdu_c2_redirect_ignored", 8'hE3);
    step("mdu_c3", 8'hE3);
    mdu_done = 1'b1;
    step("mdu_c4_done", 8'h01);
    mdu_req = 1'b0; mdu_done = 1'b0;
    step("redirect_after_mdu", 8'h0C);
    idle_inputs();

    mdu_req = 1'b1; mdu_done = 1'b1;
    step("mdu_same_cycle_done", 8'h00);
    idle_inputs();

    // Memory wait: three not-ready cycles, then ready.
    MEMre_mem = 1'b1; dmem_ready = 1'b0;
    step("mem_c0", 8'hF0);
    step("mem_c1", 8'hF1);
    step("mem_c2", 8'hF1);
    dmem_ready = 1'b1;
    step("mem_ready", 8'h01);
    idle_inputs();
    step("mem_back_to_run", 8'h00);
`ifdef HAZARD_PERF_EN
    chk("cnt_mem", cnt_mem, 32'd3);
    chk("cnt_mdu", cnt_mdu, 32'd4);
    chk("cnt_loaduse", cnt_loaduse, 32'd2);
    chk("cnt_redirect", cnt_redirect, 32'd2);
`endif

    // Memory wait has priority over an MDU request.
    MEMwe_mem = 1'b1; dmem_ready = 1'b0; mdu_req = 1'b1;
    step("mem_over_mdu", 8'hF0);
    MEMwe_mem = 1'b0; dmem_ready = 1'b1; mdu_req = 1'b0;
    step("mem_over_mdu_release", 8'h01);

    // Reset in the middle of an MDU wait.
    mdu_req = 1'b1;
    step("mdu_rst_c0", 8'hE2);
    step("mdu_rst_c1", 8'hE3);
    rstn = 1'b0;
    #1;
    chk("rst_in_mdu_wait", {24'd0, outs()}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_held", {24'd0, outs()}, 32'd0);
`ifdef HAZARD_PERF_EN
    chk("cnt_mdu_cleared", cnt_mdu, 32'd0);
`endif
    mdu_req = 1'b0;
    rstn = 1'b1;
    step("after_rst_release", 8'h00);
    step("after_rst_idle", 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
